ga23_sdr_arbiter: RTL and testbench

- Sits directly downstream of the GA23 tile layers.
- Collects one-cycle tile-row fetch requests (22-bit address) from N layer instances.
- Serialises them onto a single SDRAM graphics-ROM read port using round-robin arbitration.
- Returns each 32-bit row to its requesting layer as registered data plus a one-cycle ready pulse.

---
 rtl/ga23_pkg.sv | 12 +
 rtl/ga23_rr_pick.sv | 28 ++
 rtl/ga23_sdr_arbiter.sv | 137 +++++++++++++
 tb/tb_ga23_sdr_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ga23_pkg.sv
// Shared GA23 graphics-fetch constants and the SDRAM arbiter state type.
package ga23_pkg;

    localparam int unsigned GFX_ADDR_W = 22;
    localparam int unsigned GFX_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_t;

endpackage

// File: rtl/ga23_rr_pick.sv
// Combinational round-robin picker: first set bit of pend at or above rr_ptr, wrapping.
module ga23_rr_pick
    import ga23_pkg::*;
#(
    parameter int unsigned N     = 3,
    parameter int unsigned SEL_W = 2
) (
    input  logic [N-1:0]     pend,
    input  logic [SEL_W-1:0] rr_ptr,
    output logic [SEL_W-1:0] sel,
    output logic             valid
);

    always_comb begin
        int unsigned idx;
        idx   = 0;
        sel   = '0;
        valid = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(rr_ptr) + k) % N;
            if (!valid && pend[SEL_W'(idx)]) begin
                valid = 1'b1;
                sel   = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ga23_sdr_arbiter.sv
// Round-robin arbiter serialising GA23 tile-row fetches onto one SDRAM read port,
// single outstanding request, with per-layer registered return data and ready pulse.
module ga23_sdr_arbiter
    import ga23_pkg::*;
#(
    parameter int unsigned N_LAYERS = 3,
    parameter int unsigned ADDR_W   = GFX_ADDR_W
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_LAYERS-1:0]              layer_req,
    input  logic [N_LAYERS*ADDR_W-1:0]       layer_addr,
    output logic [N_LAYERS*GFX_DATA_W-1:0]   layer_data,
    output logic [N_LAYERS-1:0]              layer_rdy,
    output logic                             mem_req,
    output logic [ADDR_W-1:0]                mem_addr,
    input  logic                             mem_ack,
    input  logic [GFX_DATA_W-1:0]            mem_data,
    output logic                             busy
);

    localparam int unsigned SEL_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;

    arb_state_t        state;
    logic [SEL_W-1:0]  rr_ptr;
    logic [SEL_W-1:0]  cur;
    logic [SEL_W-1:0]  pick_sel;
    logic              pick_valid;
    logic              issue;
    logic              ack_ok;
    logic [N_LAYERS-1:0] pend_vec;
    logic [N_LAYERS-1:0] cand;
    logic [ADDR_W-1:0] paddr [N_LAYERS];
    logic [ADDR_W-1:0] issue_addr;

    // Fresh requests compete directly so an idle arbiter issues on the next edge.
    assign cand = pend_vec | layer_req;

    ga23_rr_pick #(
        .N     (N_LAYERS),
        .SEL_W (SEL_W)
    ) u_pick (
        .pend   (cand),
        .rr_ptr (rr_ptr),
        .sel    (pick_sel),
        .valid  (pick_valid)
    );

    assign issue  = (state == ARB_IDLE) && pick_valid;
    assign ack_ok = (state == ARB_WAIT) && mem_ack;
    assign busy   = (state == ARB_WAIT) || (|pend_vec);

    always_comb begin
        issue_addr = '0;
        for (int unsigned k = 0; k < N_LAYERS; k++) begin
            if (SEL_W'(k) == pick_sel) begin
                issue_addr = layer_req[k] ? layer_addr[k*ADDR_W +: ADDR_W] : paddr[k];
            end
        end
    end

    for (genvar i = 0; i < N_LAYERS; i++) begin : g_ch
        localparam logic [SEL_W-1:0] IDX = SEL_W'(i);

        logic                  pend_q;
        logic                  stale_q;
        logic                  rdy_q;
        logic [ADDR_W-1:0]     paddr_q;
        logic [GFX_DATA_W-1:0] data_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pend_q  <= 1'b0;
                stale_q <= 1'b0;
                rdy_q   <= 1'b0;
                paddr_q <= '0;
                data_q  <= '0;
            end else begin
                rdy_q <= 1'b0;
                if (layer_req[i]) begin
                    paddr_q <= layer_addr[i*ADDR_W +: ADDR_W];
                end
                if (issue && pick_sel == IDX) begin
                    pend_q <= 1'b0;
                end else if (layer_req[i]) begin
                    pend_q <= 1'b1;
                end
                if (issue && pick_sel == IDX) begin
                    stale_q <= 1'b0;
                end else if (layer_req[i] && state == ARB_WAIT && cur == IDX) begin
                    stale_q <= 1'b1;
                end else if (ack_ok && cur == IDX) begin
                    stale_q <= 1'b0;
                end
                if (ack_ok && cur == IDX && !stale_q) begin
                    data_q <= mem_data;
                    rdy_q  <= 1'b1;
                end
            end
        end

        assign pend_vec[i]                              = pend_q;
        assign paddr[i]                                 = paddr_q;
        assign layer_rdy[i]                             = rdy_q;
        assign layer_data[i*GFX_DATA_W +: GFX_DATA_W]   = data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            cur      <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        mem_req  <= 1'b1;
                        mem_addr <= issue_addr;
                        cur      <= pick_sel;
                        state    <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rr_ptr  <= (cur == SEL_W'(N_LAYERS - 1)) ? '0 : cur + 1'b1;
                        state   <= ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ga23_sdr_arbiter.sv
// Bench for ga23_sdr_arbiter: directed scenarios plus random bursts against a behavioural model.
module tb_ga23_sdr_arbiter;

    localparam int N  = 3;
    localparam int AW = 22;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    layer_req = '0;
    logic [N*AW-1:0] layer_addr = '0;
    logic [N*32-1:0] layer_data;
    logic [N-1:0]    layer_rdy;
    logic            mem_req;
    logic [AW-1:0]   mem_addr;
    logic            mem_ack = 1'b0;
    logic [31:0]     mem_data = '0;
    logic            busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ga23_sdr_arbiter #(.N_LAYERS(N), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .layer_req  (layer_req),
        .layer_addr (layer_addr),
        .layer_data (layer_data),
        .layer_rdy  (layer_rdy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .busy       (busy)
    );

    // Behavioural model: wanted fetch per layer, one fetch in flight, round-robin start point.
    bit            m_want [N];
    logic [AW-1:0] m_waddr [N];
    bit            m_sup [N];
    bit            m_fl;
    int            m_ch;
    logic [AW-1:0] m_addr;
    int            m_rr;
    logic [N-1:0]  m_rdy;
    logic [31:0]   m_data [N];
    int            acnt = -1;

    function automatic logic [AW-1:0] laddr(input int i);
        return layer_addr[i*AW +: AW];
    endfunction

    task automatic model_update();
        int  pick;
        bit  was_fl;
        int  was_ch;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_want[i] = 0; m_waddr[i] = '0; m_sup[i] = 0; m_data[i] = '0;
            end
            m_fl = 0; m_ch = 0; m_addr = '0; m_rr = 0; m_rdy = '0;
            return;
        end
        m_rdy  = '0;
        pick   = -1;
        was_fl = m_fl;
        was_ch = m_ch;
        if (m_fl) begin
            if (mem_ack) begin
                if (!m_sup[m_ch]) begin
                    m_rdy[m_ch]  = 1'b1;
                    m_data[m_ch] = mem_data;
                end
                m_sup[m_ch] = 0;
                m_rr = (m_ch + 1) % N;
                m_fl = 0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_rr + k) % N;
                if (pick < 0 && (m_want[c] || layer_req[c])) pick = c;
            end
            if (pick >= 0) begin
                m_fl   = 1;
                m_ch   = pick;
                m_addr = layer_req[pick] ? laddr(pick) : m_waddr[pick];
                m_want[pick] = 0;
                m_sup[pick]  = 0;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (layer_req[i] && i != pick) begin
                m_want[i]  = 1;
                m_waddr[i] = laddr(i);
                if (was_fl && was_ch == i) m_sup[i] = 1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_outputs();
        bit any_want;
        any_want = 0;
        for (int i = 0; i < N; i++) any_want |= m_want[i];
        chk("mem_req", 64'(mem_req), 64'(m_fl));
        if (m_fl) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
        chk("layer_rdy", 64'(layer_rdy), 64'(m_rdy));
        chk("busy", 64'(busy), 64'(m_fl | any_want));
        for (int i = 0; i < N; i++)
            chk($sformatf("layer_data%0d", i), 64'(layer_data[i*32 +: 32]), 64'(m_data[i]));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare_outputs();
    endtask

    task automatic set_req(input int ch, input logic [AW-1:0] a);
        layer_req[ch] = 1'b1;
        layer_addr[ch*AW +: AW] = a;
    endtask

    task automatic ack_now(input logic [31:0] d);
        mem_ack  = 1'b1;
        mem_data = d;
        step();
        mem_ack  = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        layer_req = '0;
        mem_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drive_ack();
        mem_ack = 1'b0;
        if (mem_req) begin
            if (acnt == -1) acnt = $urandom_range(0, 5);
            if (acnt == 0) begin
                mem_ack  = 1'b1;
                mem_data = {mem_addr[9:0], mem_addr} ^ 32'h5A5A_0F0F;
                acnt = -2;
            end else if (acnt > 0) begin
                acnt--;
            end
        end else begin
            acnt = -1;
            if ($urandom_range(0, 9) == 0) begin
                mem_ack  = 1'b1;
                mem_data = $urandom;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Single request on layer 1
        do_reset();
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        set_req(1, 22'h012340);
        step();
        layer_req = '0;
        chk("t1_req", 64'(mem_req), 64'd1);
        chk("t1_addr", 64'(mem_addr), 64'h012340);
        repeat (2) step();
        ack_now(32'hDEADBEEF);
        chk("t1_rdy", 64'(layer_rdy), 64'b010);
        chk("t1_data1", 64'(layer_data[63:32]), 64'hDEADBEEF);
        chk("t1_data0", 64'(layer_data[31:0]), 64'd0);
        chk("t1_data2", 64'(layer_data[95:64]), 64'd0);
        step();
        chk("t1_rdy_once", 64'(layer_rdy), 64'd0);

        // Simultaneous requests on all layers
        do_reset();
        set_req(0, 22'h100);
        set_req(1, 22'h200);
        set_req(2, 22'h300);
        step();
        layer_req = '0;
        for (int ch = 0; ch < N; ch++) begin
            chk($sformatf("t2_addr%0d", ch), 64'(mem_addr), 64'((ch + 1) * 'h100));
            repeat (2) step();
            ack_now(32'hC0DE0000 + 32'(ch));
            chk($sformatf("t2_rdy%0d", ch), 64'(layer_rdy), 64'(1 << ch));
            step();
        end
        chk("t2_idle", 64'(mem_req), 64'd0);
        set_req(0, 22'h400);
        set_req(2, 22'h600);
        step();
        layer_req = '0;
        chk("t2_rr0", 64'(mem_addr), 64'h400);
        ack_now(32'h1);
        chk("t2_rr0_rdy", 64'(layer_rdy), 64'b001);
        step();
        chk("t2_rr2", 64'(mem_addr), 64'h600);
        ack_now(32'h2);
        chk("t2_rr2_rdy", 64'(layer_rdy), 64'b100);

        // Overwrite while pending
        do_reset();
        set_req(0, 22'h050);
        step();
        layer_req = '0;
        set_req(2, 22'h111);
        step();
        set_req(2, 22'h222);
        step();
        layer_req = '0;
        ack_now(32'h11);
        step();
        chk("t3_req", 64'(mem_req), 64'd1);
        chk("t3_addr", 64'(mem_addr), 64'h222);
        ack_now(32'h22);
        chk("t3_rdy", 64'(layer_rdy), 64'b100);
        chk("t3_data2", 64'(layer_data[95:64]), 64'h22);
        step();
        chk("t3_one_fetch", 64'(mem_req), 64'd0);
        chk("t3_busy", 64'(busy), 64'd0);

        // Supersede in flight
        do_reset();
        set_req(1, 22'h500);
        step();
        layer_req = '0;
        chk("t4_addr0", 64'(mem_addr), 64'h500);
        set_req(1, 22'h600);
        step();
        layer_req = '0;
        step();
        ack_now(32'hAAAA0000);
        chk("t4_no_rdy", 64'(layer_rdy), 64'd0);
        step();
        chk("t4_req", 64'(mem_req), 64'd1);
        chk("t4_addr1", 64'(mem_addr), 64'h600);
        ack_now(32'hBBBB0000);
        chk("t4_rdy", 64'(layer_rdy), 64'b010);
        chk("t4_data1", 64'(layer_data[63:32]), 64'hBBBB0000);

        // Reset mid-WAIT
        do_reset();
        set_req(0, 22'h700);
        step();
        layer_req = '0;
        chk("t5_req", 64'(mem_req), 64'd1);
        chk("t5_addr", 64'(mem_addr), 64'h700);
        step();
        reset = 1'b1;
        #1;
        chk("t5_req_rst", 64'(mem_req), 64'd0);
        chk("t5_busy_rst", 64'(busy), 64'd0);
        chk("t5_rdy_rst", 64'(layer_rdy), 64'd0);
        for (int i = 0; i < N; i++)
            chk($sformatf("t5_data%0d", i), 64'(layer_data[i*32 +: 32]), 64'd0);
        step();
        reset = 1'b0;
        step();
        ack_now(32'h12345678);
        chk("t5_late_ack", 64'(layer_rdy), 64'd0);
        step();
        chk("t5_idle", 64'(mem_req), 64'd0);

        // Random bursts with 1-6 cycle ack delays
        do_reset();
        acnt = -1;
        for (int b = 0; b < 50; b++) begin
            int len;
            int gap;
            len = $urandom_range(1, 8);
            gap = $urandom_range(0, 10);
            for (int c = 0; c < len + gap; c++) begin
                layer_req = (c < len) ? (N'($urandom) & N'($urandom)) : '0;
                for (int i = 0; i < N; i++) layer_addr[i*AW +: AW] = AW'($urandom);
                drive_ack();
                step();
            end
        end
        layer_req = '0;
        n = 0;
        while ((busy || mem_req) && n < 200) begin
            drive_ack();
            step();
            n++;
        end
        mem_ack = 1'b0;
        chk("drain_timeout", 64'(n < 200), 64'd1);
        step();
        chk("drain_idle", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
